// File: rtl/shift_sub_divider_pkg.sv
// Shared types for the shift-and-subtract divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

endpackage

// File: rtl/shift_sub_divider_shifter.sv
// shifterHI: left-shifting A:Q register with parallel load.
// Serial-in enters at the LSB (quotient bit), serial-out leaves at the MSB.
module shifterHI #(
  parameter int W = 17
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         mode,
  input  logic         enable,
  input  logic [W-1:0] par_in,
  input  logic         serial_in,
  output logic         serial_out,
  output logic [W-2:0] data_out
);

  logic [W-1:0] r;

  // Parallel load has priority over the shift.
  always_ff @(posedge CLOCK) begin
    if (RESET)       r <= '0;
    else if (mode)   r <= par_in;
    else if (enable) r <= {r[W-2:0], serial_in};
  end

  assign serial_out = r[W-1];
  assign data_out   = r[W-2:0];

endmodule

// File: rtl/shift_sub_divider.sv
// Radix-2 restoring unsigned divider: FSM, counter, subtractor and restore mux
// around a left-shifting A:Q register.
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = $clog2(size + 1);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  div_state_t        state;
  logic [size-1:0]   d;
  logic [CW-1:0]     cnt;
  logic [2*size-1:0] aq;          // A[size-1:0] : Q
  logic              sign_unused; // A[size] is always 0 once an iteration settles
  logic [size:0]     t;
  logic              ld, sh;
  logic [2*size:0]   ld_val;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign t = {aq[2*size-1:size], aq[size-1]} - {1'b0, d};

  // Load on accept or on a successful subtract; plain shift on restore.
  always_comb begin
    ld     = 1'b0;
    sh     = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: if (start) begin
        ld = 1'b1;
        if (divisor == '0) ld_val = {1'b0, dividend, {size{1'b1}}};
        else               ld_val = {{(size+1){1'b0}}, dividend};
      end
      CALC: if (t[size]) sh = 1'b1;
            else begin
              ld     = 1'b1;
              ld_val = {t, aq[size-2:0], 1'b1};
            end
      default: ;
    endcase
  end

  // The restore path shifts in quotient bit 0, so serial-in is tied low.
  shifterHI #(.W(2*size+1)) u_shift (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .mode       (ld),
    .enable     (sh),
    .par_in     (ld_val),
    .serial_in  (1'b0),
    .serial_out (sign_unused),
    .data_out   (aq)
  );

  // Control FSM, iteration counter, divisor and error flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      d           <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          if (divisor == '0) begin
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            div_by_zero <= 1'b0;
            d           <= divisor;
            state       <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign quotient  = aq[size-1:0];
  assign remainder = aq[2*size-1:size];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized self-checking bench for shift_sub_divider (size = 8),
// checked against plain integer division.
module tb_shift_sub_divider;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  shift_sub_divider #(.size(8)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done; lat counts cycles from E0 to the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge CLOCK);
      lat++;
    end
  endtask

  // Issue one operation and check it against integer division.
  task automatic run_op(input int dd, input int dv);
    int lat, q, r;
    @(negedge CLOCK);
    dividend = 8'(dd); divisor = 8'(dv); start = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
    dividend = 8'($urandom_range(0, 255)); divisor = 8'($urandom_range(0, 255));
    wait_done(lat);
    if (dv == 0) begin q = 255; r = dd; end
    else begin q = dd / dv; r = dd % dv; end
    chk("latency", 32'(lat), (dv == 0) ? 32'd1 : 32'd9);
    chk("quotient", 32'(quotient), 32'(q));
    chk("remainder", 32'(remainder), 32'(r));
    chk("div_by_zero", 32'(div_by_zero), (dv == 0) ? 32'd1 : 32'd0);
    if (dv != 0) begin
      chk("invariant", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
      chk("rem_lt_div", 32'(remainder < 8'(dv)), 32'd1);
    end
    @(negedge CLOCK);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("result_hold", {24'd0, quotient}, 32'(q));
  endtask

  initial begin
    int lat, dd, dv;
    bit seen;
    RESET = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge CLOCK);
    chk("reset_state", {13'd0, quotient, remainder, busy, done, div_by_zero}, 32'd0);
    RESET = 1'b0;

    // Normal divide and boundaries
    run_op(100, 7);
    run_op(255, 1);
    run_op(5, 9);
    run_op(255, 255);
    run_op(128, 2);

    // Divide by zero, then flag clears
    run_op(77, 0);
    run_op(10, 3);

    // Start held high while busy: second op only on first IDLE edge
    @(negedge CLOCK);
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    @(negedge CLOCK);
    dividend = 8'd50; divisor = 8'd5;
    wait_done(lat);
    chk("busy1_latency", 32'(lat), 32'd9);
    chk("busy1_q", 32'(quotient), 32'd22);
    chk("busy1_r", 32'(remainder), 32'd2);
    @(negedge CLOCK);
    chk("busy_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge CLOCK);
    chk("busy2_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(lat);
    chk("busy2_latency", 32'(lat), 32'd9);
    chk("busy2_q", 32'(quotient), 32'd10);
    chk("busy2_r", 32'(remainder), 32'd0);
    @(negedge CLOCK);

    // Reset mid-operation, asserted so it is sampled at E3
    @(negedge CLOCK);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge CLOCK);   // after E0
    start = 1'b0;
    @(negedge CLOCK);   // after E1
    @(negedge CLOCK);   // after E2
    RESET = 1'b1;
    @(negedge CLOCK);   // after E3
    chk("reset_mid", {13'd0, quotient, remainder, busy, done, div_by_zero}, 32'd0);
    RESET = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLOCK);
      if (done) seen = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, seen}, 32'd0);
    run_op(100, 7);

    // Randomized sweep
    for (int i = 0; i < 1000; i++) begin
      dd = int'($urandom_range(0, 255));
      dv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(dd, dv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Radix-2 restoring shift-and-subtract unsigned divider. It is the inverse companion of the sum-and-shift multiplier.
- The multiplier's operand register shifts right and emits low bits.
- This block's register pair shifts left, takes in one quotient bit per cycle at the LSB, and feeds the remainder from the MSB side.
- It sits beside the multiplier in the arithmetic datapath and uses the same start/done handshake.

## Interface
- `size`, default 8, is the operand width for dividend, divisor, quotient and remainder (size ≥ 2).
- `CLOCK` input, 1 bit: the single clock. All state updates on its rising edge.
- `RESET` input, 1 bit: reset is synchronous and active-high. One clock (`CLOCK`); reset is synchronous and active-high.
- `start` input, 1 bit: operation request, sampled only in IDLE.
- `dividend` input, `size` bits: unsigned, captured on the accepting edge.
- `divisor` input, `size` bits: unsigned, captured on the accepting edge.
- `quotient` output, `size` bits: registered result.
- `remainder` output, `size` bits: registered result.
- `busy` output, 1 bit: high in CALC and DONE.
- `done` output, 1 bit: one-cycle pulse; results are valid from this cycle onward.
- `div_by_zero` output, 1 bit: error flag for the last operation. Held until the next accepted start.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- Working registers:
  - A, `size+1` bits: partial remainder with a sign/borrow bit.
  - Q, `size` bits: dividend/quotient.
  - D, `size` bits: divisor.
  - cnt, `$clog2(size+1)` bits: iteration counter.
- **IDLE with `start`=1 and `divisor`≠0:** set A=0, Q=`dividend`, D=`divisor`, cnt=0, `div_by_zero`=0, then go to CALC.
- **IDLE with `start`=1 and `divisor`=0:** set Q=all ones, A=`dividend` (zero-extended), `div_by_zero`=1, then go directly to DONE.
- **CALC iteration, one per cycle:**
  - Form T = {A[size-1:0], Q[size-1]} − {1'b0, D}, as a `size+1`-bit difference.
  - If T[size]=1 (negative): A ← {A[size-1:0], Q[size-1]} and Q ← {Q[size-2:0], 1'b0}. This is the restore path.
  - Otherwise: A ← T and Q ← {Q[size-2:0], 1'b1}.
  - cnt increments. When cnt = size−1 on that edge, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go unconditionally to IDLE.
- **Outputs:** `quotient` = Q and `remainder` = A[size-1:0]. Both are held unchanged in IDLE until the next accepted start.
- **Invariant:** after a normal operation, A[size]=0 and dividend = quotient·divisor + remainder, with remainder < divisor.
- **`start` while busy:** ignored, no queuing. `start` during the DONE cycle is also ignored.
- **`dividend` and `divisor` changes after the accepting edge:** have no effect.
- **Reset value of every register and output:** 0. State = IDLE. `busy`=`done`=`div_by_zero`=0.
- **`RESET` mid-operation:** aborts on the next edge with the same reset values. `RESET` has priority over `start`.

## Timing
- Define E0 as the rising edge that samples `start`=1 in IDLE.
- **Normal operation:**
  - Iterations occur at edges E1..E_size.
  - `done` is high in the cycle following edge E_size, for one cycle.
  - Latency from E0 to the `done` cycle is `size`+1 edges (9 for `size`=8).
  - The earliest next accepting edge is E_size+2.
- **Divide-by-zero:** `done` is high in the cycle following E0. The next start can be accepted at E2.
- **`busy`:** rises in the cycle after E0 and falls in the cycle after the `done` cycle.
- **Result timing:** results are stable from the `done` cycle until the cycle after the next E0.

## Structure
- **Package `div_pkg`:** holds the `typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t`.
- **Parameter-dependent items:** widths and the iteration bound stay in the module.
- **Sub-module `shifterHI`:**
  - Left-shifting mirror of the multiplier's right shifter.
  - Shifts A:Q as one `2*size+1`-bit register.
  - Parallel-load `mode`, `enable`, serial-in at LSB (the quotient bit), serial-out at MSB.
  - Same synchronous active-high `RESET`.
- **Top level:** FSM, counter, subtractor and restore mux.

## Test plan
All scenarios use `size`=8.
1. **Normal divide:** reset for 2 cycles, then `dividend`=100, `divisor`=7, pulse `start`. Required: `quotient`=14, `remainder`=2, `div_by_zero`=0, and `done` in exactly the 9th cycle after E0.
2. **Boundary values:**
   - 255/1 → 255 r 0.
   - 5/9 → 0 r 5.
   - 255/255 → 1 r 0.
   - 128/2 → 64 r 0.
3. **Divide-by-zero:** 77/0. Required: `done` in the cycle after E0, `quotient`=255, `remainder`=77, `div_by_zero`=1. Then run 10/3 and check 3 r 1 with the flag cleared.
4. **Start while busy:**
   - Start 200/9.
   - Hold `start`=1 with new operands (50/5) through CALC and DONE.
   - Required: first result 22 r 2.
   - The second operation starts only on the first IDLE edge and gives 10 r 0.
5. **Reset mid-operation:** assert `RESET` at E3 of 100/7. Required: all outputs 0 and IDLE next cycle, no `done` pulse. A fresh 100/7 then gives 14 r 2.
6. **Randomized sweep (self-checking):** 1000 random operand pairs, including divisor 0. Check the invariant dividend = q·d + r with r < d, and check the `done` latency.
